// File: rtl/unified_buffer_port_arbiter.sv
// Arbitrates the single-port unified buffer SRAM: streaming reads win, the host and accumulator
// writers round-robin in idle read cycles, and a per-writer wait counter forces a write slot.
module unified_buffer_port_arbiter #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 256,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_stall_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,

    input  logic              host_wr_valid_i,
    input  logic [ADDR_W-1:0] host_wr_addr_i,
    input  logic [DATA_W-1:0] host_wr_data_i,
    output logic              host_wr_ready_o,

    input  logic              acc_wr_valid_i,
    input  logic [ADDR_W-1:0] acc_wr_addr_i,
    input  logic [DATA_W-1:0] acc_wr_data_i,
    output logic              acc_wr_ready_o,

    output logic              ub_en_o,
    output logic              ub_we_o,
    output logic [ADDR_W-1:0] ub_addr_o,
    output logic [DATA_W-1:0] ub_wdata_o,
    input  logic [DATA_W-1:0] ub_rdata_i
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WaitMax = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WaitOne = WAIT_W'(1);

    typedef enum logic [1:0] {GntNone, GntRead, GntHost, GntAcc} grant_e;

    grant_e            grant;
    logic              host_starved;
    logic              acc_starved;

    logic              rr_ptr_q, rr_ptr_d;  // 0 favours host, 1 favours acc
    logic [WAIT_W-1:0] host_wait_q, host_wait_d;
    logic [WAIT_W-1:0] acc_wait_q, acc_wait_d;

    logic              ub_en_q, ub_en_d;
    logic              ub_we_q, ub_we_d;
    logic [ADDR_W-1:0] ub_addr_q, ub_addr_d;
    logic [DATA_W-1:0] ub_wdata_q, ub_wdata_d;

    logic [RD_LAT:0]   rd_pipe_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    // Grant decision; nothing is granted while reset is asserted.
    always_comb begin
        grant        = GntNone;
        rd_stall_o   = 1'b0;
        host_starved = host_wr_valid_i && (host_wait_q == WaitMax);
        acc_starved  = acc_wr_valid_i && (acc_wait_q == WaitMax);
        if (!rst_i) begin
            grant = GntNone;
        end else if (host_starved || acc_starved) begin
            rd_stall_o = rd_req_i;
            if (host_starved && acc_starved) begin
                grant = rr_ptr_q ? GntAcc : GntHost;
            end else begin
                grant = host_starved ? GntHost : GntAcc;
            end
        end else if (rd_req_i) begin
            grant = GntRead;
        end else if (host_wr_valid_i && acc_wr_valid_i) begin
            grant = rr_ptr_q ? GntAcc : GntHost;
        end else if (host_wr_valid_i) begin
            grant = GntHost;
        end else if (acc_wr_valid_i) begin
            grant = GntAcc;
        end
    end

    assign host_wr_ready_o = (grant == GntHost);
    assign acc_wr_ready_o  = (grant == GntAcc);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant == GntHost) begin
            rr_ptr_d = 1'b1;
        end else if (grant == GntAcc) begin
            rr_ptr_d = 1'b0;
        end

        host_wait_d = '0;
        if (host_wr_valid_i && !host_wr_ready_o) begin
            host_wait_d = (host_wait_q == WaitMax) ? WaitMax : host_wait_q + WaitOne;
        end

        acc_wait_d = '0;
        if (acc_wr_valid_i && !acc_wr_ready_o) begin
            acc_wait_d = (acc_wait_q == WaitMax) ? WaitMax : acc_wait_q + WaitOne;
        end
    end

    // Write data is left untouched on reads and idle cycles.
    always_comb begin
        ub_en_d    = 1'b0;
        ub_we_d    = 1'b0;
        ub_addr_d  = ub_addr_q;
        ub_wdata_d = ub_wdata_q;
        unique case (grant)
            GntRead: begin
                ub_en_d   = 1'b1;
                ub_addr_d = rd_addr_i;
            end
            GntHost: begin
                ub_en_d    = 1'b1;
                ub_we_d    = 1'b1;
                ub_addr_d  = host_wr_addr_i;
                ub_wdata_d = host_wr_data_i;
            end
            GntAcc: begin
                ub_en_d    = 1'b1;
                ub_we_d    = 1'b1;
                ub_addr_d  = acc_wr_addr_i;
                ub_wdata_d = acc_wr_data_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rr_ptr_q    <= 1'b0;
            host_wait_q <= '0;
            acc_wait_q  <= '0;
            ub_en_q     <= 1'b0;
            ub_we_q     <= 1'b0;
            ub_addr_q   <= '0;
            ub_wdata_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            host_wait_q <= host_wait_d;
            acc_wait_q  <= acc_wait_d;
            ub_en_q     <= ub_en_d;
            ub_we_q     <= ub_we_d;
            ub_addr_q   <= ub_addr_d;
            ub_wdata_q  <= ub_wdata_d;
        end
    end

    // Stage 0 marks a read command on the SRAM pins; stage RD_LAT lines up with its data.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_pipe_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_pipe_q  <= {rd_pipe_q[RD_LAT-1:0], grant == GntRead};
            rd_valid_q <= rd_pipe_q[RD_LAT];
            if (rd_pipe_q[RD_LAT]) begin
                rd_data_q <= ub_rdata_i;
            end
        end
    end

    assign ub_en_o    = ub_en_q;
    assign ub_we_o    = ub_we_q;
    assign ub_addr_o  = ub_addr_q;
    assign ub_wdata_o = ub_wdata_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

    a_one_writer : assert property (@(posedge clk_i) disable iff (!rst_i)
        !(host_wr_ready_o && acc_wr_ready_o));
    a_stall_needs_req : assert property (@(posedge clk_i) disable iff (!rst_i)
        rd_stall_o |-> rd_req_i);

endmodule

// File: tb/tb_unified_buffer_port_arbiter.sv
// Bench for unified_buffer_port_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level reference model.
module tb_unified_buffer_port_arbiter;

    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned DATA_W   = 256;
    localparam int unsigned RD_LAT   = 1;
    localparam int unsigned MAX_WAIT = 16;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              rd_req_i = 1'b0;
    logic [ADDR_W-1:0] rd_addr_i = '0;
    logic              rd_stall_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic              host_wr_valid_i = 1'b0;
    logic [ADDR_W-1:0] host_wr_addr_i = '0;
    logic [DATA_W-1:0] host_wr_data_i = '0;
    logic              host_wr_ready_o;
    logic              acc_wr_valid_i = 1'b0;
    logic [ADDR_W-1:0] acc_wr_addr_i = '0;
    logic [DATA_W-1:0] acc_wr_data_i = '0;
    logic              acc_wr_ready_o;
    logic              ub_en_o;
    logic              ub_we_o;
    logic [ADDR_W-1:0] ub_addr_o;
    logic [DATA_W-1:0] ub_wdata_o;
    logic [DATA_W-1:0] ub_rdata_i;

    unified_buffer_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RD_LAT  (RD_LAT),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rd_req_i       (rd_req_i),
        .rd_addr_i      (rd_addr_i),
        .rd_stall_o     (rd_stall_o),
        .rd_data_o      (rd_data_o),
        .rd_valid_o     (rd_valid_o),
        .host_wr_valid_i(host_wr_valid_i),
        .host_wr_addr_i (host_wr_addr_i),
        .host_wr_data_i (host_wr_data_i),
        .host_wr_ready_o(host_wr_ready_o),
        .acc_wr_valid_i (acc_wr_valid_i),
        .acc_wr_addr_i  (acc_wr_addr_i),
        .acc_wr_data_i  (acc_wr_data_i),
        .acc_wr_ready_o (acc_wr_ready_o),
        .ub_en_o        (ub_en_o),
        .ub_we_o        (ub_we_o),
        .ub_addr_o      (ub_addr_o),
        .ub_wdata_o     (ub_wdata_o),
        .ub_rdata_i     (ub_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Unwritten SRAM words read back as their own address.
    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        return DATA_W'(a);
    endfunction

    // SRAM stub: command seen during a cycle is executed at the closing edge.
    logic              cmd_en, cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] sram [int];
    logic [DATA_W-1:0] rdata_pipe [RD_LAT];

    always @(negedge clk_i) begin
        cmd_en    = ub_en_o;
        cmd_we    = ub_we_o;
        cmd_addr  = ub_addr_o;
        cmd_wdata = ub_wdata_o;
    end

    always @(posedge clk_i) begin
        #1;
        for (int i = RD_LAT - 1; i > 0; i--) rdata_pipe[i] = rdata_pipe[i - 1];
        rdata_pipe[0] = {8{$urandom}};
        if (cmd_en === 1'b1 && cmd_we === 1'b0) begin
            rdata_pipe[0] = sram.exists(int'(cmd_addr)) ? sram[int'(cmd_addr)]
                                                        : init_word(cmd_addr);
        end
        if (cmd_en === 1'b1 && cmd_we === 1'b1) sram[int'(cmd_addr)] = cmd_wdata;
    end

    assign ub_rdata_i = rdata_pipe[RD_LAT - 1];

    // Reference model: per-cycle grant from the arbitration rules, expected SRAM command,
    // and a queue of read returns tagged with the cycle they must appear in.
    typedef struct {
        int unsigned       due;
        logic [DATA_W-1:0] data;
    } ret_t;

    ret_t              ret_q [$];
    logic [DATA_W-1:0] ref_mem [int];
    int unsigned       m_wait [2];
    int                m_ptr;
    bit                m_en, m_we, m_after_rst, armed;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rdata;
    int unsigned       cyc = 0;

    always @(negedge clk_i) begin
        bit                v [2];
        bit                starve [2];
        logic [ADDR_W-1:0] wa [2];
        logic [DATA_W-1:0] wd [2];
        int                gw;
        bit                grd, exp_stall, exp_valid;
        ret_t              r;

        v  = '{host_wr_valid_i, acc_wr_valid_i};
        wa = '{host_wr_addr_i, acc_wr_addr_i};
        wd = '{host_wr_data_i, acc_wr_data_i};
        gw = -1;
        grd = 1'b0;
        exp_stall = 1'b0;
        if (rst_i) begin
            for (int w = 0; w < 2; w++) starve[w] = v[w] && (m_wait[w] == MAX_WAIT);
            if (starve[0] || starve[1]) begin
                gw = (starve[0] && starve[1]) ? m_ptr : (starve[0] ? 0 : 1);
                exp_stall = rd_req_i;
            end else if (rd_req_i) begin
                grd = 1'b1;
            end else if (v[0] || v[1]) begin
                gw = (v[0] && v[1]) ? m_ptr : (v[0] ? 0 : 1);
            end
        end

        exp_valid = 1'b0;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            exp_valid = 1'b1;
            m_rdata   = ret_q[0].data;
            void'(ret_q.pop_front());
        end

        if (armed) begin
            check("host_ready", host_wr_ready_o, gw == 0);
            check("acc_ready", acc_wr_ready_o, gw == 1);
            check("rd_stall", rd_stall_o, exp_stall);
            check("rd_valid", rd_valid_o, exp_valid);
            check("rd_data", rd_data_o, m_rdata);
            check("ub_en", ub_en_o, m_en);
            check("ub_we", ub_we_o, m_we);
            if (m_en || m_after_rst) check("ub_addr", ub_addr_o, m_addr);
            if ((m_en && m_we) || m_after_rst) check("ub_wdata", ub_wdata_o, m_wdata);
        end

        if (!rst_i) begin
            m_wait      = '{0, 0};
            m_ptr       = 0;
            m_en        = 1'b0;
            m_we        = 1'b0;
            m_addr      = '0;
            m_wdata     = '0;
            m_rdata     = '0;
            m_after_rst = 1'b1;
            ret_q.delete();
            armed = 1'b1;
        end else begin
            m_after_rst = 1'b0;
            for (int w = 0; w < 2; w++) begin
                if (v[w] && gw != w) m_wait[w] = (m_wait[w] < MAX_WAIT) ? m_wait[w] + 1 : MAX_WAIT;
                else m_wait[w] = 0;
            end
            if (gw >= 0) begin
                m_ptr   = 1 - gw;
                m_en    = 1'b1;
                m_we    = 1'b1;
                m_addr  = wa[gw];
                m_wdata = wd[gw];
                ref_mem[int'(wa[gw])] = wd[gw];
            end else if (grd) begin
                m_en   = 1'b1;
                m_we   = 1'b0;
                m_addr = rd_addr_i;
                r.due  = cyc + 2 + RD_LAT;
                r.data = ref_mem.exists(int'(rd_addr_i)) ? ref_mem[int'(rd_addr_i)]
                                                         : init_word(rd_addr_i);
                ret_q.push_back(r);
            end else begin
                m_en = 1'b0;
                m_we = 1'b0;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_idle();
        rd_req_i        = 1'b0;
        host_wr_valid_i = 1'b0;
        acc_wr_valid_i  = 1'b0;
    endtask

    bit host_took, acc_took, rd_took, exp_v;
    int rd_pct;

    initial begin
        // Reset held with every request high.
        rd_req_i        = 1'b1;
        rd_addr_i       = 12'h033;
        host_wr_valid_i = 1'b1;
        host_wr_addr_i  = 12'h0aa;
        host_wr_data_i  = DATA_W'(32'hdead);
        acc_wr_valid_i  = 1'b1;
        acc_wr_addr_i   = 12'h0bb;
        acc_wr_data_i   = DATA_W'(32'hbeef);
        step();
        step();
        #3;
        check("rst_rd_valid", rd_valid_o, 0);
        check("rst_rd_data", rd_data_o, 0);
        check("rst_ub_en", ub_en_o, 0);
        check("rst_host_ready", host_wr_ready_o, 0);
        check("rst_rd_stall", rd_stall_o, 0);
        step();
        rst_i = 1'b1;
        #3;
        check("first_gnt_stall", rd_stall_o, 0);
        check("first_gnt_host", host_wr_ready_o, 0);
        check("first_gnt_acc", acc_wr_ready_o, 0);
        step();
        set_idle();
        #3;
        check("first_gnt_en", ub_en_o, 1);
        check("first_gnt_we", ub_we_o, 0);
        check("first_gnt_addr", ub_addr_o, 12'h033);
        repeat (6) step();

        // Eight back-to-back reads.
        for (int k = 0; k < 12; k++) begin
            rd_req_i  = (k < 8);
            rd_addr_i = ADDR_W'(16 + k);
            #3;
            if (k < 8) check("stream_stall", rd_stall_o, 0);
            exp_v = (k >= 3 && k <= 10);
            check("stream_valid", rd_valid_o, exp_v);
            if (exp_v) check("stream_data", rd_data_o, DATA_W'(16 + k - 3));
            step();
        end
        set_idle();
        repeat (3) step();

        // Both writers valid, no reads: strict alternation starting with host.
        host_wr_addr_i = 12'h100;
        host_wr_data_i = DATA_W'(32'h1111);
        acc_wr_addr_i  = 12'h200;
        acc_wr_data_i  = DATA_W'(32'h2222);
        for (int k = 0; k < 5; k++) begin
            host_wr_valid_i = (k < 4);
            acc_wr_valid_i  = (k < 4);
            #3;
            if (k < 4) begin
                check("rr_host_ready", host_wr_ready_o, (k % 2) == 0);
                check("rr_acc_ready", acc_wr_ready_o, (k % 2) == 1);
            end
            if (k >= 1) begin
                check("rr_ub_we", ub_we_o, 1);
                check("rr_ub_addr", ub_addr_o, ((k - 1) % 2 == 0) ? 12'h100 : 12'h200);
            end
            step();
        end
        set_idle();
        repeat (3) step();

        // Continuous reads with a waiting host write: forced slot in cycle 16.
        host_wr_addr_i = 12'h0ab;
        host_wr_data_i = DATA_W'(32'h5a5a);
        for (int k = 0; k < 25; k++) begin
            rd_req_i        = (k < 20);
            rd_addr_i       = ADDR_W'(768 + ((k <= 16) ? k : k - 1));
            host_wr_valid_i = (k <= 16);
            #3;
            if (k < 20) begin
                check("starve_host_ready", host_wr_ready_o, k == 16);
                check("starve_rd_stall", rd_stall_o, k == 16);
            end
            exp_v = (k >= 3 && k != 19 && k <= 22);
            check("starve_rd_valid", rd_valid_o, exp_v);
            if (exp_v) begin
                check("starve_rd_data", rd_data_o,
                      DATA_W'(768 + ((k - 3 <= 16) ? k - 3 : k - 4)));
            end
            step();
        end
        set_idle();
        repeat (3) step();

        // Read-after-write to the same address.
        acc_wr_addr_i = 12'h050;
        acc_wr_data_i = DATA_W'(8'haa);
        rd_addr_i     = 12'h050;
        for (int k = 0; k < 6; k++) begin
            acc_wr_valid_i = (k == 0);
            rd_req_i       = (k == 1);
            #3;
            if (k == 0) check("raw_acc_ready", acc_wr_ready_o, 1);
            if (k == 1) check("raw_rd_stall", rd_stall_o, 0);
            if (k == 4) begin
                check("raw_rd_valid", rd_valid_o, 1);
                check("raw_rd_data", rd_data_o, 8'haa);
            end
            step();
        end
        set_idle();
        repeat (3) step();

        // Reset one cycle after two accepted reads; pointer must return to host.
        host_wr_addr_i = 12'h070;
        acc_wr_addr_i  = 12'h071;
        for (int k = 0; k < 10; k++) begin
            rst_i           = (k != 3);
            host_wr_valid_i = (k == 0 || k == 4);
            acc_wr_valid_i  = (k >= 1 && k <= 4);
            rd_req_i        = (k == 1 || k == 2);
            rd_addr_i       = ADDR_W'(96 + k - 1);
            #3;
            if (k == 0) check("mid_host_ready", host_wr_ready_o, 1);
            if (k == 3) begin
                check("mid_rst_host_ready", host_wr_ready_o, 0);
                check("mid_rst_acc_ready", acc_wr_ready_o, 0);
            end
            if (k == 4) begin
                check("mid_ptr_host_ready", host_wr_ready_o, 1);
                check("mid_ptr_acc_ready", acc_wr_ready_o, 0);
            end
            if (k >= 3) check("mid_no_rd_valid", rd_valid_o, 0);
            step();
        end
        set_idle();
        repeat (3) step();

        // Randomized traffic; requesters hold their request until it is accepted.
        host_took = 1'b0;
        acc_took  = 1'b0;
        rd_took   = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            case ((n / 500) % 4)
                0:       rd_pct = 90;
                1:       rd_pct = 50;
                2:       rd_pct = 100;
                default: rd_pct = 10;
            endcase
            if (!host_wr_valid_i || host_took) begin
                host_wr_valid_i = ($urandom_range(0, 99) < 40);
                host_wr_addr_i  = ADDR_W'($urandom_range(0, 31));
                host_wr_data_i  = {8{$urandom}};
            end else if ($urandom_range(0, 99) < 3) begin
                host_wr_valid_i = 1'b0;
            end
            if (!acc_wr_valid_i || acc_took) begin
                acc_wr_valid_i = ($urandom_range(0, 99) < 40);
                acc_wr_addr_i  = ADDR_W'($urandom_range(0, 31));
                acc_wr_data_i  = {8{$urandom}};
            end else if ($urandom_range(0, 99) < 3) begin
                acc_wr_valid_i = 1'b0;
            end
            if (!rd_req_i || rd_took) begin
                rd_req_i  = ($urandom_range(0, 99) < rd_pct);
                rd_addr_i = ADDR_W'($urandom_range(0, 31));
            end
            rst_i = ($urandom_range(0, 299) != 0);
            #3;
            host_took = host_wr_valid_i && host_wr_ready_o;
            acc_took  = acc_wr_valid_i && acc_wr_ready_o;
            rd_took   = rd_req_i && !rd_stall_o;
            step();
        end
        rst_i = 1'b1;
        set_idle();
        repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/unified_buffer_port_arbiter.md
Name: unified_buffer_port_arbiter

Overview:
- Shares the single-port unified buffer SRAM between three requesters:
  - the unified buffer read sequencer, which streams activations into the systolic array;
  - host writes, which load input tiles;
  - accumulator writeback, which stores output tiles.
- Streaming reads have priority. Writers are round-robined in idle read cycles.
- A starvation guard forces a one-cycle read stall so that no writer waits unboundedly.
- All SRAM commands are registered. Read data returns through an aligned valid pipeline.

Parameters:
- ADDR_W, 12, unified buffer address width.
- DATA_W, 256, unified buffer word width (32 lanes x 8 bit).
- RD_LAT, 1, SRAM read latency in cycles from registered command to ub_rdata_i valid (1..4).
- MAX_WAIT, 16, cycles a writer may wait before a forced write slot (2..255).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- rd_req_i  in  1  read request from read sequencer.
- rd_addr_i  in  ADDR_W  read address.
- rd_stall_o  out  1  read not accepted this cycle; sequencer holds rd_addr_i.
- rd_data_o  out  DATA_W  returned read word.
- rd_valid_o  out  1  rd_data_o valid.
- host_wr_valid_i  in  1  host write request.
- host_wr_addr_i  in  ADDR_W  host write address.
- host_wr_data_i  in  DATA_W  host write data.
- host_wr_ready_o  out  1  host write accepted this cycle.
- acc_wr_valid_i  in  1  accumulator writeback request.
- acc_wr_addr_i  in  ADDR_W  writeback address.
- acc_wr_data_i  in  DATA_W  writeback data.
- acc_wr_ready_o  out  1  writeback accepted this cycle.
- ub_en_o  out  1  SRAM enable.
- ub_we_o  out  1  SRAM write enable.
- ub_addr_o  out  ADDR_W  SRAM address.
- ub_wdata_o  out  DATA_W  SRAM write data.
- ub_rdata_i  in  DATA_W  SRAM read data.

Behaviour:

Reset (rst_i=0 at a clock edge):
- All outputs are 0.
- Both wait counters are 0.
- The round-robin pointer selects host.
- The read-valid pipeline is flushed. Reads in flight are dropped and no rd_valid_o pulse follows.
- Reset mid-transfer is legal. A granted but unissued command is discarded.

Handshake:
- A transfer occurs when valid and ready are both 1 in the same cycle.
- ready and rd_stall_o are combinational from the current inputs and state.
- Requesters hold valid, address and data stable until accepted.
- A read is accepted when rd_req_i=1 and rd_stall_o=0.

Per-cycle grant, at most one:
1. force_wr = (host_wait==MAX_WAIT & host_wr_valid_i) | (acc_wait==MAX_WAIT & acc_wr_valid_i).
   - If force_wr: grant the starved writer. If both are starved, the round-robin pointer picks.
   - rd_stall_o = rd_req_i.
2. Else if rd_req_i: grant the read. rd_stall_o=0 and both ready outputs are 0.
3. Else: grant a valid writer. If both are valid, the pointer picks.

Round-robin pointer:
- After a write grant, the pointer moves to the other writer.
- Unchanged on read or idle cycles.

Wait counters, one per writer:
- +1 when valid=1 and ready=0, saturating at MAX_WAIT.
- Cleared when ready=1 or valid=0.

SRAM command timing:
- A grant in cycle t registers ub_en_o=1 and ub_we_o/ub_addr_o/ub_wdata_o at the t+1 edge.
- Read: ub_we_o=0 and ub_wdata_o holds its previous value. Write: ub_we_o=1.
- In idle cycles ub_en_o=0 and ub_we_o=0.

Read return:
- ub_rdata_i is sampled RD_LAT cycles after the command cycle and registered into rd_data_o.
- rd_valid_o is high for exactly the matching cycle.
- Total latency from accept cycle t to rd_valid_o is t+2+RD_LAT.
- rd_data_o holds its value when rd_valid_o=0.

Ordering and throughput:
- Accesses reach the SRAM in grant order, so a read after a granted write to the same address returns the new data.
- Back-to-back reads sustain 1 per cycle. rd_valid_o mirrors the accept pattern, including stall bubbles.

Boundaries:
- Addresses are used unmodified, with no wrap logic.
- Simultaneous writer valids with no read alternate strictly host, acc, host, ...
- A writer deasserting valid before it is granted is legal and clears its counter.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles with all requests high, then release -> all outputs 0 during reset. First grant goes to the read, with ub_addr_o at the next edge.
- Read stream latency (RD_LAT=1): rd_req_i=1 for 8 cycles, addresses 0x010..0x017; the SRAM model returns data=addr -> rd_valid_o high cycles t+3..t+10 with data 0x010..0x017 in order, and rd_stall_o=0 throughout.
- Writer round-robin: rd_req_i=0, both writers valid continuously at addresses 0x100 (host) and 0x200 (acc) -> ub_addr_o sequence 0x100, 0x200, 0x100, 0x200 with ub_we_o=1.
- Starvation (MAX_WAIT=16): rd_req_i=1 continuously and host_wr_valid_i=1 from cycle 0 -> host_wr_ready_o=1 and rd_stall_o=1 exactly in cycle 16. Reads resume in cycle 17 with no lost rd_valid_o beats.
- RAW ordering: acc writes 0xAA to address 0x050 in cycle t and a read of 0x050 is accepted in cycle t+1 -> the read returns 0xAA.
- Reset mid-stream: assert rst_i=0 one cycle after 2 reads are accepted -> no rd_valid_o pulse after reset, and the counters and pointer return to reset values.
